// File: rtl/debug_unit.sv
// Debug controller: decodes host command bytes to load instruction memory, run/step the CPU and
// stream the register file or a pipeline latch back LSB-first; each byte waits on the transmitter's done pulse.
module debug_unit #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int IF_ID_SIZE      = 32,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 77,
  parameter int MEM_WB_SIZE     = 71
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_imem_we,
  output logic [31:0]            o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  output logic                   o_cpu_stall,
  output logic                   o_cpu_rst,
  output logic [4:0]             o_reg_addr,
  input  logic [SIZE-1:0]        i_reg_data,
  input  logic [IF_ID_SIZE-1:0]  i_if_id,
  input  logic [ID_EX_SIZE-1:0]  i_id_ex,
  input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
  input  logic                   i_halt
);

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, SEND_LOAD, SEND_BYTE, SEND_WAIT
  } state_t;

  localparam logic [7:0] CMD_REGS      = 8'h01;
  localparam logic [7:0] CMD_IF_ID     = 8'h02;
  localparam logic [7:0] CMD_ID_EX     = 8'h03;
  localparam logic [7:0] CMD_EX_MEM    = 8'h04;
  localparam logic [7:0] CMD_MEM_WB    = 8'h05;
  localparam logic [7:0] CMD_LOAD      = 8'h07;
  localparam logic [7:0] CMD_CONT      = 8'h08;
  localparam logic [7:0] CMD_STEP_MODE = 8'h09;
  localparam logic [7:0] CMD_STEP      = 8'h0A;
  localparam logic [7:0] CMD_START     = 8'h0D;

  localparam int CW           = $clog2(MAX_INSTRUCTION + 1);
  localparam int IF_ID_BYTES  = (IF_ID_SIZE + 7) / 8;
  localparam int ID_EX_BYTES  = (ID_EX_SIZE + 7) / 8;
  localparam int EX_MEM_BYTES = (EX_MEM_SIZE + 7) / 8;
  localparam int MEM_WB_BYTES = (MEM_WB_SIZE + 7) / 8;
  localparam int MAX_A        = (IF_ID_BYTES > ID_EX_BYTES) ? IF_ID_BYTES : ID_EX_BYTES;
  localparam int MAX_B        = (EX_MEM_BYTES > MEM_WB_BYTES) ? EX_MEM_BYTES : MEM_WB_BYTES;
  localparam int BUFW         = 8 * ((MAX_A > MAX_B) ? MAX_A : MAX_B);

  state_t          state, state_nxt;
  logic            step_mode, running, step_pulse, cpu_rst_q;
  logic [CW-1:0]   instr_cnt, instr_idx;
  logic [1:0]      byte_idx;
  logic [31:0]     word_asm;
  logic [2:0]      sel_q;
  logic [BUFW-1:0] send_buf;
  logic [7:0]      send_idx, send_total;
  logic            dump_regs;

  assign dump_regs = (sel_q == 3'd1);

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_tx_start  = 1'b0;
    o_tx_data   = '0;
    o_reg_addr  = '0;
    o_imem_we   = 1'b0;
    o_imem_addr = '0;
    o_imem_data = '0;
    o_cpu_rst   = cpu_rst_q;
    // The CPU only runs from IDLE; any load or dump freezes it.
    o_cpu_stall = !((state == IDLE) && running && (!step_mode || step_pulse));
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_nxt = LOAD_CNT;
            CMD_REGS, CMD_IF_ID, CMD_ID_EX, CMD_EX_MEM, CMD_MEM_WB: state_nxt = SEND_LOAD;
            default: state_nxt = IDLE;
          endcase
        end
      end
      LOAD_CNT:  if (i_rx_valid) state_nxt = (i_rx_data == 8'd0) ? IDLE : LOAD_BYTE;
      LOAD_BYTE: if (i_rx_valid && byte_idx == 2'd3) state_nxt = LOAD_WRITE;
      LOAD_WRITE: begin
        o_imem_we   = 1'b1;
        o_imem_addr = {{(30-CW){1'b0}}, instr_idx, 2'b00};
        o_imem_data = SIZE'(word_asm);
        state_nxt   = (instr_idx == instr_cnt - CW'(1)) ? IDLE : LOAD_BYTE;
      end
      SEND_LOAD: state_nxt = SEND_BYTE;
      SEND_BYTE, SEND_WAIT: begin
        o_tx_start = (state == SEND_BYTE);
        if (dump_regs) begin
          o_reg_addr = send_idx[6:2];
          o_tx_data  = i_reg_data[{send_idx[1:0], 3'b000} +: 8];
        end else begin
          o_tx_data  = 8'(send_buf >> {send_idx, 3'b000});
        end
        if (state == SEND_BYTE)
          state_nxt = SEND_WAIT;
        else if (i_tx_done)
          state_nxt = (send_idx == send_total - 8'd1) ? IDLE : SEND_BYTE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      step_mode  <= 1'b0;
      running    <= 1'b0;
      step_pulse <= 1'b0;
      cpu_rst_q  <= 1'b0;
      instr_cnt  <= '0;
      instr_idx  <= '0;
      byte_idx   <= '0;
      word_asm   <= '0;
      sel_q      <= '0;
      send_buf   <= '0;
      send_idx   <= '0;
      send_total <= '0;
    end else begin
      step_pulse <= 1'b0;
      cpu_rst_q  <= 1'b0;
      if (cpu_rst_q) running <= 1'b1;
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD:      running   <= 1'b0;
              CMD_CONT:      step_mode <= 1'b0;
              CMD_STEP_MODE: step_mode <= 1'b1;
              CMD_STEP:      if (running && step_mode && !i_halt) step_pulse <= 1'b1;
              CMD_START:     cpu_rst_q <= 1'b1;
              CMD_REGS, CMD_IF_ID, CMD_ID_EX, CMD_EX_MEM, CMD_MEM_WB: sel_q <= i_rx_data[2:0];
              default: ;
            endcase
          end
        end
        LOAD_CNT: begin
          if (i_rx_valid) begin
            instr_cnt <= (int'(i_rx_data) > MAX_INSTRUCTION) ? CW'(MAX_INSTRUCTION) : CW'(i_rx_data);
            instr_idx <= '0;
            byte_idx  <= '0;
          end
        end
        LOAD_BYTE: begin
          if (i_rx_valid) begin
            word_asm[{byte_idx, 3'b000} +: 8] <= i_rx_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        LOAD_WRITE: instr_idx <= instr_idx + CW'(1);
        SEND_LOAD: begin
          send_idx <= '0;
          case (sel_q)
            3'd2:    begin send_buf <= BUFW'(i_if_id);  send_total <= 8'(IF_ID_BYTES);  end
            3'd3:    begin send_buf <= BUFW'(i_id_ex);  send_total <= 8'(ID_EX_BYTES);  end
            3'd4:    begin send_buf <= BUFW'(i_ex_mem); send_total <= 8'(EX_MEM_BYTES); end
            3'd5:    begin send_buf <= BUFW'(i_mem_wb); send_total <= 8'(MEM_WB_BYTES); end
            default: begin send_buf <= '0;              send_total <= 8'd128;          end
          endcase
        end
        SEND_WAIT: if (i_tx_done) send_idx <= send_idx + 8'd1;
        default: ;
      endcase
      // Halt has the last word so it beats a coincident step or start.
      if (i_halt) running <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
// Directed bench for debug_unit: table of latch-dump commands plus hand sequences for load, step, register dump and reset.
module tb_debug_unit;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_done = 1'b0;
  logic         imem_we;
  logic [31:0]  imem_addr, imem_data;
  logic         cpu_stall, cpu_rst;
  logic [4:0]   reg_addr;
  logic [31:0]  reg_data;
  logic [31:0]  if_id = 32'hA1B2C3D4;
  logic [128:0] id_ex;
  logic [76:0]  ex_mem;
  logic [70:0]  mem_wb;
  logic         halt = 1'b0;

  int passed = 0, total = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] we_addr_q[$], we_data_q[$];
  int both_viol = 0, dbl_start = 0, rst_cycles = 0, low_cycles = 0, windows = 0;
  logic prev_stall = 1'b1;

  typedef struct { logic [7:0] cmd; int cnt; logic [7:0] first; logic [7:0] last; } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  assign reg_data = {27'd0, reg_addr};

  debug_unit dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
    .o_cpu_stall(cpu_stall), .o_cpu_rst(cpu_rst),
    .o_reg_addr(reg_addr), .i_reg_data(reg_data),
    .i_if_id(if_id), .i_id_ex(id_ex), .i_ex_mem(ex_mem), .i_mem_wb(mem_wb),
    .i_halt(halt)
  );

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      we_addr_q.push_back(imem_addr);
      we_data_q.push_back(imem_data);
    end
    if (tx_start === 1'b1) tx_q.push_back(tx_data);
    if (tx_start === 1'b1 && imem_we === 1'b1) both_viol++;
    if (cpu_rst === 1'b1) rst_cycles++;
    if (cpu_stall === 1'b0) begin
      low_cycles++;
      if (prev_stall) windows++;
    end
    prev_stall = (cpu_stall !== 1'b0);
  end

  // Transmitter model: done pulse three cycles after each start; a second start before done is flagged.
  initial begin
    forever begin
      @(negedge clk);
      while (tx_start === 1'b1) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (tx_start === 1'b1) dbl_start++;
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
  endtask

  function automatic logic [7:0] tx_at(input int i);
    return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
  endfunction

  function automatic logic [31:0] wa_at(input int i);
    return (i < we_addr_q.size()) ? we_addr_q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    return (i < we_data_q.size()) ? we_data_q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] cmd, input int k);
    logic [135:0] p;
    p = '0;
    case (cmd)
      8'h02:   p[31:0]  = if_id;
      8'h03:   p[128:0] = id_ex;
      8'h04:   p[76:0]  = ex_mem;
      8'h05:   p[70:0]  = mem_wb;
      default: p = '0;
    endcase
    return p[k*8 +: 8];
  endfunction

  initial begin
    int tb, wb, lc, errs;
    id_ex  = '0; id_ex[128] = 1'b1; id_ex[7:0] = 8'h5A; id_ex[71:64] = 8'h77;
    ex_mem = '0; ex_mem[76:72] = 5'h1F; ex_mem[7:0] = 8'h33; ex_mem[47:40] = 8'h9E;
    mem_wb = '0; mem_wb[70:64] = 7'h55; mem_wb[7:0] = 8'hC7; mem_wb[31:24] = 8'h12;
    vecs[0] = '{8'h02, 4,  8'hD4, 8'hA1};
    vecs[1] = '{8'h03, 17, 8'h5A, 8'h01};
    vecs[2] = '{8'h04, 10, 8'h33, 8'h1F};
    vecs[3] = '{8'h05, 9,  8'hC7, 8'h55};
    vecs[4] = '{8'h06, 0,  8'h00, 8'h00};
    vecs[5] = '{8'h0B, 0,  8'h00, 8'h00};
    vecs[6] = '{8'hFF, 0,  8'h00, 8'h00};
    vecs[7] = '{8'h00, 0,  8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_stall",     64'(cpu_stall), 64'd1);
    check("rst_cpu_rst",   64'(cpu_rst),   64'd0);
    check("rst_tx_start",  64'(tx_start),  64'd0);
    check("rst_imem_we",   64'(imem_we),   64'd0);
    check("rst_tx_data",   64'(tx_data),   64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_data", 64'(imem_data), 64'd0);
    check("rst_reg_addr",  64'(reg_addr),  64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      tb = tx_q.size();
      send_byte(vecs[v].cmd);
      wait_tx(tb + vecs[v].cnt, 400);
      repeat (12) @(negedge clk);
      check($sformatf("cmd%02h_count", vecs[v].cmd), 64'(tx_q.size() - tb), 64'(vecs[v].cnt));
      if (vecs[v].cnt > 0) begin
        check($sformatf("cmd%02h_first", vecs[v].cmd), 64'(tx_at(tb)), 64'(vecs[v].first));
        check($sformatf("cmd%02h_last", vecs[v].cmd), 64'(tx_at(tb + vecs[v].cnt - 1)), 64'(vecs[v].last));
        errs = 0;
        for (int k = 0; k < vecs[v].cnt; k++)
          if (tx_at(tb + k) !== exp_byte(vecs[v].cmd, k)) errs++;
        check($sformatf("cmd%02h_bytes", vecs[v].cmd), 64'(errs), 64'd0);
      end
      check($sformatf("cmd%02h_stall", vecs[v].cmd), 64'(cpu_stall), 64'd1);
    end

    // Register dump with start and load bytes arriving mid-dump.
    tb = tx_q.size();
    wb = we_addr_q.size();
    lc = rst_cycles;
    send_byte(8'h01);
    wait_tx(tb + 5, 200);
    send_byte(8'h0D);
    wait_tx(tb + 40, 400);
    check("regs_stall_mid", 64'(cpu_stall), 64'd1);
    send_byte(8'h07);
    wait_tx(tb + 128, 2000);
    repeat (12) @(negedge clk);
    check("regs_count", 64'(tx_q.size() - tb), 64'd128);
    errs = 0;
    for (int i = 0; i < 128; i++)
      if (tx_at(tb + i) !== ((i % 4 == 0) ? 8'(i / 4) : 8'h00)) errs++;
    check("regs_bytes", 64'(errs), 64'd0);
    check("regs_dropped_start", 64'(rst_cycles - lc), 64'd0);
    check("regs_dropped_load", 64'(we_addr_q.size() - wb), 64'd0);
    tb = tx_q.size();
    send_byte(8'h02);
    wait_tx(tb + 4, 200);
    repeat (12) @(negedge clk);
    check("regs_then_idle", 64'(tx_q.size() - tb), 64'd4);

    // Two-instruction load.
    wb = we_addr_q.size();
    send_byte(8'h07); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h3C);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h3C);
    repeat (5) @(negedge clk);
    check("load2_count", 64'(we_addr_q.size() - wb), 64'd2);
    check("load2_addr0", 64'(wa_at(wb)),     64'h0);
    check("load2_data0", 64'(wd_at(wb)),     64'h3C010003);
    check("load2_addr1", 64'(wa_at(wb + 1)), 64'h4);
    check("load2_data1", 64'(wd_at(wb + 1)), 64'h3C020000);

    // Zero-length load, then a saturated load of 64 words.
    wb = we_addr_q.size();
    send_byte(8'h07); send_byte(8'h00);
    repeat (5) @(negedge clk);
    check("load0_count", 64'(we_addr_q.size() - wb), 64'd0);
    send_byte(8'h07); send_byte(8'hFF);
    for (int j = 0; j < 256; j++) send_byte(8'(j));
    repeat (5) @(negedge clk);
    check("load64_count", 64'(we_addr_q.size() - wb), 64'd64);
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      if (wa_at(wb + k) !== 32'(4 * k)) errs++;
      if (wd_at(wb + k) !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) errs++;
    end
    check("load64_words", 64'(errs), 64'd0);
    tb = tx_q.size();
    send_byte(8'h02);
    wait_tx(tb + 4, 200);
    repeat (12) @(negedge clk);
    check("load64_then_idle", 64'(tx_q.size() - tb), 64'd4);

    // Step mode: one CPU reset pulse, then three single-cycle run windows.
    lc = low_cycles;
    wb = windows;
    tb = rst_cycles;
    send_byte(8'h09); send_byte(8'h0D);
    repeat (5) @(negedge clk);
    check("step_rst_pulse", 64'(rst_cycles - tb), 64'd1);
    check("step_stalled", 64'(low_cycles - lc), 64'd0);
    send_byte(8'h0A); send_byte(8'h0A); send_byte(8'h0A);
    repeat (5) @(negedge clk);
    check("step_windows", 64'(windows - wb), 64'd3);
    check("step_low_cycles", 64'(low_cycles - lc), 64'd3);
    send_byte(8'h08);
    repeat (3) @(negedge clk);
    check("cont_runs", 64'(cpu_stall), 64'd0);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (2) @(negedge clk);
    check("halt_stalls", 64'(cpu_stall), 64'd1);

    // Halt coincident with a step wins; a later step is ignored because the CPU is no longer running.
    send_byte(8'h09); send_byte(8'h0D);
    repeat (5) @(negedge clk);
    lc = low_cycles;
    @(negedge clk);
    rx_data = 8'h0A; rx_valid = 1'b1; halt = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; halt = 1'b0;
    repeat (5) @(negedge clk);
    check("halt_beats_step", 64'(low_cycles - lc), 64'd0);
    send_byte(8'h0A);
    repeat (5) @(negedge clk);
    check("step_after_halt", 64'(low_cycles - lc), 64'd0);

    // Reset in the middle of a load aborts it.
    wb = we_addr_q.size();
    send_byte(8'h07); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_stall", 64'(cpu_stall), 64'd1);
    rst_n = 1'b1;
    send_byte(8'hCC); send_byte(8'hDD);
    repeat (5) @(negedge clk);
    check("midrst_no_write", 64'(we_addr_q.size() - wb), 64'd0);
    tb = tx_q.size();
    send_byte(8'h01);
    wait_tx(tb + 128, 2000);
    repeat (12) @(negedge clk);
    check("midrst_regs_count", 64'(tx_q.size() - tb), 64'd128);
    check("midrst_regs_byte4", 64'(tx_at(tb + 4)), 64'h01);

    check("tx_we_overlap", 64'(both_viol), 64'd0);
    check("start_per_done", 64'(dbl_start), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning CPU word width.
REQ-002 SHALL have parameter MAX_INSTRUCTION, default 64, meaning instruction-memory depth in words.
REQ-003 SHALL have parameters IF_ID_SIZE/ID_EX_SIZE/EX_MEM_SIZE/MEM_WB_SIZE, defaults 32/129/77/71, meaning pipeline-latch widths.
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have i_rx_data (input, 8) and i_rx_valid (input, 1): received byte, qualified by a one-cycle pulse.
REQ-007 SHALL have o_tx_data (output, 8), o_tx_start (output, 1) and i_tx_done (input, 1): byte to transmit, start pulse, and one-cycle completion pulse from the transmitter.
REQ-008 SHALL have o_imem_we (output, 1), o_imem_addr (output, 32) and o_imem_data (output, SIZE): instruction-memory write port, byte address.
REQ-009 SHALL have o_cpu_stall (output, 1) and o_cpu_rst (output, 1): pipeline freeze and CPU reset pulse.
REQ-010 SHALL have o_reg_addr (output, 5) and i_reg_data (input, SIZE): register-file read port, combinational read.
REQ-011 SHALL have i_if_id, i_id_ex, i_ex_mem and i_mem_wb (inputs, widths per REQ-003) carrying the latch contents, plus i_halt (input, 1) signalling program end.

Function
REQ-012 SHALL decode command bytes only in state IDLE: 0x01 regs, 0x02 IF/ID, 0x03 ID/EX, 0x04 EX/MEM, 0x05 MEM/WB, 0x07 load, 0x08 continuous mode, 0x09 step mode, 0x0A step, 0x0D start.
REQ-013 SHALL ignore any other byte and remain in IDLE.
REQ-014 SHALL drop bytes arriving in any state other than IDLE, LOAD_CNT or LOAD_BYTE.
REQ-015 SHALL use FSM states IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, SEND_LOAD, SEND_BYTE and SEND_WAIT.
REQ-016 SHALL, on 0x07, go to LOAD_CNT; the next byte N sets the instruction count, saturated to MAX_INSTRUCTION.
REQ-017 SHALL return to IDLE with no writes when N = 0.
REQ-018 SHALL assemble each instruction in LOAD_BYTE from 4 bytes, least-significant byte first.
REQ-019 SHALL, after the 4th byte, spend one cycle in LOAD_WRITE asserting o_imem_we with o_imem_addr = 4*k and o_imem_data = word, where k = 0..N-1.
REQ-020 SHALL return to IDLE after the N-th write.
REQ-021 SHALL hold o_cpu_stall = 1 throughout loading and clear the running flag.
REQ-022 SHALL, on 0x08/0x09, set or clear the step_mode flag; if running, o_cpu_stall takes effect the next cycle (0 in continuous mode, 1 in step mode).
REQ-023 SHALL, on 0x0D, pulse o_cpu_rst for exactly 1 cycle and set running the following cycle.
REQ-024 SHALL, while running and not in step mode, drive o_cpu_stall = 0; otherwise o_cpu_stall = 1.
REQ-025 SHALL, on 0x0A when running and in step mode, deassert o_cpu_stall for exactly 1 cycle; otherwise 0x0A is ignored.
REQ-026 SHALL, on i_halt = 1, clear running (o_cpu_stall = 1 next cycle); i_halt coincident with 0x0A SHALL win.
REQ-027 SHALL, on 0x01, force o_cpu_stall = 1 during the dump and send 128 bytes: R0..R31, each 4 bytes LSB-first, sampled via o_reg_addr.
REQ-028 SHALL, on 0x02..0x05, snapshot the selected latch in SEND_LOAD and send ceil(width/8) bytes LSB-first, zero-padding the top byte (4/17/10/9 bytes at defaults).
REQ-029 SHALL drive o_tx_start for 1 cycle per byte in SEND_BYTE, then wait in SEND_WAIT for i_tx_done before the next byte.
REQ-030 SHALL return to IDLE after the last i_tx_done and restore o_cpu_stall per REQ-024.
REQ-031 SHALL guarantee o_tx_start and o_imem_we are never asserted in the same cycle.

Reset
REQ-032 SHALL, with i_rst = 0 at a rising edge, enter IDLE and clear step_mode, running, counters and assembly registers.
REQ-033 SHALL hold these reset output values: o_cpu_stall = 1, o_cpu_rst = 0, o_tx_start = 0, o_imem_we = 0, o_tx_data = 0, o_imem_addr = 0, o_imem_data = 0, o_reg_addr = 0.
REQ-034 SHALL, on reset mid-load or mid-dump, abort immediately with no further writes or start pulses.

Verification
REQ-035 Bench SHALL cover: 0x07, 0x02, bytes 03 00 01 3C, 0x00 00 02 3C -> two o_imem_we pulses, addr 0 data 0x3C010003, addr 4 data 0x3C020000.
REQ-036 Bench SHALL cover: 0x07, 0x00 -> no o_imem_we, IDLE; a following 0x07, 0xFF (MAX 64) -> exactly 64 writes after 256 bytes.
REQ-037 Bench SHALL cover: 0x09, 0x0D, 0x0A x3 -> one o_cpu_rst pulse, then exactly three 1-cycle o_cpu_stall = 0 windows.
REQ-038 Bench SHALL cover: 0x01 with Rk = k -> 128 bytes, byte 4k = k and others 0, one o_tx_start per i_tx_done, bytes received mid-dump dropped.
REQ-039 Bench SHALL cover: 0x03 with i_id_ex bit128 = 1 -> 17 bytes, last byte = 0x01.
REQ-040 Bench SHALL cover: i_rst = 0 after the 2nd byte of a load -> no o_imem_we; next 0x01 after reset is decoded normally.
